// File: rtl/game_stats_tracker_if.sv
// Control/display bus for the game statistics tracker: start and pair-match
// pulses in, frozen endgame statistics out.
interface game_stats_tracker_if;
    logic        start;
    logic        pair_found;
    logic [12:0] game_time;
    logic [5:0]  discovered_pairs_ctr;
    logic        game_over_en;
    logic        game_won;
    logic        running;

    modport master (
        output start, pair_found,
        input  game_time, discovered_pairs_ctr, game_over_en, game_won, running
    );

    modport slave (
        input  start, pair_found,
        output game_time, discovered_pairs_ctr, game_over_en, game_won, running
    );
endinterface

// File: rtl/game_stats_tracker.sv
// Game timer and pair counter: counts hundredths of a second while a game runs
// and freezes everything once all pairs are found or the time limit is hit.
module game_stats_tracker #(
    parameter int CLK_FREQ_HZ  = 65_000_000,
    parameter int TOTAL_PAIRS  = 18,
    parameter int TIME_LIMIT_S = 59
) (
    input  logic                 pclk,
    input  logic                 rst,
    game_stats_tracker_if.slave  bus
);
    localparam int DIV = CLK_FREQ_HZ / 100;
    localparam int PW  = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, RUNNING, OVER} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [5:0]      sec_q, sec_d;
    logic [6:0]      hun_q, hun_d;
    logic [5:0]      pairs_q, pairs_d;
    logic            won_q, won_d;
    logic            running_q, over_q;
    logic            tick;

    assign tick = (state_q == RUNNING) && (presc_q == PW'(DIV - 1));

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            sec_q     <= '0;
            hun_q     <= '0;
            pairs_q   <= '0;
            won_q     <= 1'b0;
            running_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            hun_q     <= hun_d;
            pairs_q   <= pairs_d;
            won_q     <= won_d;
            running_q <= (state_d == RUNNING);
            over_q    <= (state_d == OVER);
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        hun_d   = hun_q;
        pairs_d = pairs_q;
        won_d   = won_q;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d = RUNNING;
                    sec_d   = '0;
                    hun_d   = '0;
                    pairs_d = '0;
                    won_d   = 1'b0;
                end
            end
            RUNNING: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                // A win wins over a same-cycle tick: that tick is simply dropped.
                if (bus.pair_found && pairs_q == 6'(TOTAL_PAIRS - 1)) begin
                    pairs_d = 6'(TOTAL_PAIRS);
                    won_d   = 1'b1;
                    state_d = OVER;
                end else begin
                    if (bus.pair_found)
                        pairs_d = pairs_q + 1'b1;
                    if (tick) begin
                        if (hun_q == 7'd99) begin
                            hun_d = '0;
                            sec_d = sec_q + 1'b1;
                            if (sec_q == 6'(TIME_LIMIT_S - 1)) begin
                                won_d   = 1'b0;
                                state_d = OVER;
                            end
                        end else begin
                            hun_d = hun_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Prescaler restarts from zero so every game's first tick is a full period away.
        if (state_d != RUNNING)
            presc_d = '0;
    end

    assign bus.game_time            = {sec_q, hun_q};
    assign bus.discovered_pairs_ctr = pairs_q;
    assign bus.game_over_en         = over_q;
    assign bus.game_won             = won_q;
    assign bus.running              = running_q;
endmodule

// File: tb/tb_game_stats_tracker.sv
// Directed bench for game_stats_tracker with 10 cycles per tick, 3 pairs, 2 s limit.
module tb_game_stats_tracker;
    logic pclk = 1'b0;
    logic rst  = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    game_stats_tracker_if bus();

    game_stats_tracker #(
        .CLK_FREQ_HZ (1000),
        .TOTAL_PAIRS (3),
        .TIME_LIMIT_S(2)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus)
    );

    always #5 pclk = ~pclk;

    // {seconds, hundredths, pairs, game_over_en, game_won, running}
    logic [21:0] st;
    assign st = {bus.game_time, bus.discovered_pairs_ctr, bus.game_over_en, bus.game_won, bus.running};

    function automatic logic [21:0] exp_st(input int s, input int h, input int p,
                                           input bit o, input bit w, input bit r);
        return {6'(s), 7'(h), 6'(p), o, w, r};
    endfunction

    // Advance to 1 ns after edge number 'target' counted from the start edge.
    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge pclk);
            #1;
            cyc++;
        end
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        @(posedge pclk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
    endtask

    task automatic do_reset();
        bus.start      = 1'b0;
        bus.pair_found = 1'b0;
        rst = 1'b1;
        @(posedge pclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pair_at(input int k);
        run_to(k - 1);
        bus.pair_found = 1'b1;
        run_to(k);
        bus.pair_found = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.pair_found = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (st !== exp_st(0, 0, 0, 0, 0, 0)) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", st, exp_st(0, 0, 0, 0, 0, 0));
        end
        cyc = 0;
        for (int i = 5; i <= 50; i += 5) pair_at(i);
        n_cmp++;
        if (st !== exp_st(0, 0, 0, 0, 0, 0)) begin
            n_bad++; $display("FAIL idle_pairs_ignored: got %h want %h", st, exp_st(0, 0, 0, 0, 0, 0));
        end
        run_to(80);
        n_cmp++;
        if (bus.game_time !== 13'd0) begin
            n_bad++; $display("FAIL idle_time_static: got %h want %h", bus.game_time, 13'd0);
        end
    endtask

    task automatic test_time_wrap();
        do_reset();
        start_game();
        run_to(9);
        n_cmp++;
        if (st !== exp_st(0, 0, 0, 0, 0, 1)) begin
            n_bad++; $display("FAIL pre_first_tick: got %h want %h", st, exp_st(0, 0, 0, 0, 0, 1));
        end
        run_to(10);
        n_cmp++;
        if (st !== exp_st(0, 1, 0, 0, 0, 1)) begin
            n_bad++; $display("FAIL first_tick: got %h want %h", st, exp_st(0, 1, 0, 0, 0, 1));
        end
        run_to(990);
        n_cmp++;
        if (st !== exp_st(0, 99, 0, 0, 0, 1)) begin
            n_bad++; $display("FAIL time_0_99: got %h want %h", st, exp_st(0, 99, 0, 0, 0, 1));
        end
        run_to(1000);
        n_cmp++;
        if (st !== exp_st(1, 0, 0, 0, 0, 1)) begin
            n_bad++; $display("FAIL time_wrap_1_0: got %h want %h", st, exp_st(1, 0, 0, 0, 0, 1));
        end
    endtask

    task automatic test_win();
        do_reset();
        start_game();
        pair_at(20);
        pair_at(40);
        run_to(54);
        n_cmp++;
        if (st !== exp_st(0, 5, 2, 0, 0, 1)) begin
            n_bad++; $display("FAIL win_pre: got %h want %h", st, exp_st(0, 5, 2, 0, 0, 1));
        end
        pair_at(55);
        n_cmp++;
        if (st !== exp_st(0, 5, 3, 1, 1, 0)) begin
            n_bad++; $display("FAIL win: got %h want %h", st, exp_st(0, 5, 3, 1, 1, 0));
        end
        for (int k = 100; k <= 250; k += 50) pair_at(k);
        run_to(255);
        n_cmp++;
        if (st !== exp_st(0, 5, 3, 1, 1, 0)) begin
            n_bad++; $display("FAIL win_frozen: got %h want %h", st, exp_st(0, 5, 3, 1, 1, 0));
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start_game();
        pair_at(10);
        run_to(1999);
        n_cmp++;
        if (st !== exp_st(1, 99, 1, 0, 0, 1)) begin
            n_bad++; $display("FAIL timeout_pre: got %h want %h", st, exp_st(1, 99, 1, 0, 0, 1));
        end
        run_to(2000);
        n_cmp++;
        if (st !== exp_st(2, 0, 1, 1, 0, 0)) begin
            n_bad++; $display("FAIL timeout: got %h want %h", st, exp_st(2, 0, 1, 1, 0, 0));
        end
        pair_at(2050);
        run_to(2100);
        n_cmp++;
        if (st !== exp_st(2, 0, 1, 1, 0, 0)) begin
            n_bad++; $display("FAIL timeout_frozen: got %h want %h", st, exp_st(2, 0, 1, 1, 0, 0));
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        start_game();
        pair_at(100);
        pair_at(200);
        pair_at(2000);
        n_cmp++;
        if (st !== exp_st(1, 99, 3, 1, 1, 0)) begin
            n_bad++; $display("FAIL win_vs_timeout: got %h want %h", st, exp_st(1, 99, 3, 1, 1, 0));
        end
    endtask

    task automatic test_restart();
        start_game();
        n_cmp++;
        if (st !== exp_st(0, 0, 0, 0, 0, 1)) begin
            n_bad++; $display("FAIL restart_clear: got %h want %h", st, exp_st(0, 0, 0, 0, 0, 1));
        end
        pair_at(15);
        run_to(25);
        n_cmp++;
        if (st !== exp_st(0, 2, 1, 0, 0, 1)) begin
            n_bad++; $display("FAIL restart_run: got %h want %h", st, exp_st(0, 2, 1, 0, 0, 1));
        end
    endtask

    task automatic test_reset_midgame();
        do_reset();
        start_game();
        pair_at(100);
        run_to(299);
        rst = 1'b1;
        run_to(300);
        rst = 1'b0;
        n_cmp++;
        if (st !== exp_st(0, 0, 0, 0, 0, 0)) begin
            n_bad++; $display("FAIL midgame_reset: got %h want %h", st, exp_st(0, 0, 0, 0, 0, 0));
        end
        run_to(330);
        n_cmp++;
        if (st !== exp_st(0, 0, 0, 0, 0, 0)) begin
            n_bad++; $display("FAIL post_reset_idle: got %h want %h", st, exp_st(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_start_held();
        do_reset();
        start_game();
        pair_at(30);
        run_to(50);
        bus.start = 1'b1;
        run_to(55);
        bus.start = 1'b0;
        n_cmp++;
        if (st !== exp_st(0, 5, 1, 0, 0, 1)) begin
            n_bad++; $display("FAIL start_held: got %h want %h", st, exp_st(0, 5, 1, 0, 0, 1));
        end
        run_to(60);
        n_cmp++;
        if (st !== exp_st(0, 6, 1, 0, 0, 1)) begin
            n_bad++; $display("FAIL start_held_run: got %h want %h", st, exp_st(0, 6, 1, 0, 0, 1));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_game();
        run_to(9);
        bus.pair_found = 1'b1;
        run_to(11);
        n_cmp++;
        if (st !== exp_st(0, 1, 2, 0, 0, 1)) begin
            n_bad++; $display("FAIL held_pair_count: got %h want %h", st, exp_st(0, 1, 2, 0, 0, 1));
        end
        run_to(12);
        bus.pair_found = 1'b0;
        n_cmp++;
        if (st !== exp_st(0, 1, 3, 1, 1, 0)) begin
            n_bad++; $display("FAIL held_pair_win: got %h want %h", st, exp_st(0, 1, 3, 1, 1, 0));
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.pair_found = 1'b0;
        test_reset();
        test_time_wrap();
        test_win();
        test_timeout();
        test_simultaneous();
        test_restart();
        test_reset_midgame();
        test_start_held();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
